// File: rtl/shifter.sv
// shifter: registered 8-bit logical left and right barrel shifter, 3-bit amount
module shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic       s0,
  input  logic       s1,
  input  logic       s2,
  output logic [7:0] oL,
  output logic [7:0] oR
);
  logic [7:0] l1, l2, l3;
  logic [7:0] r1, r2, r3;
  // log shifter: stage 1 shifts by 1 (s2), stage 2 by 2 (s1), stage 3 by 4 (s0), both directions
  always_comb begin
    l1 = s2 ? {a[6:0], 1'b0} : a;
    l2 = s1 ? {l1[5:0], 2'b0} : l1;
    l3 = s0 ? {l2[3:0], 4'b0} : l2;
    r1 = s2 ? {1'b0, a[7:1]} : a;
    r2 = s1 ? {2'b0, r1[7:2]} : r1;
    r3 = s0 ? {4'b0, r2[7:4]} : r2;
  end
  // output registers; reset clears them immediately and drops any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oL <= 8'h00;
      oR <= 8'h00;
    end else begin
      oL <= l3;
      oR <= r3;
    end
  end
endmodule

// File: tb/tb_shifter.sv
// tb_shifter: scoreboard bench for the registered left/right shifter
module tb_shifter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic       s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic [7:0] oL, oR;
  int         total = 0;
  int         bad = 0;
  logic [15:0] sb[$];
  logic [15:0] last_e;
  bit          have_last = 1'b0;

  shifter dut (
    .clk(clk), .rst_n(rst_n), .a(a), .s0(s0), .s1(s1), .s2(s2), .oL(oL), .oR(oR)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // apply inputs at the falling edge; outputs must not move until the next rising edge
  task automatic drive(input logic [7:0] va, input logic [2:0] n);
    logic [7:0] el, er;
    @(negedge clk);
    a = va;
    {s0, s1, s2} = n;
    el = va << n;
    er = va >> n;
    sb.push_back({el, er});
    #1;
    if (have_last) begin
      check("hold_l", oL, last_e[15:8]);
      check("hold_r", oR, last_e[7:0]);
    end
  endtask

  task automatic collect(input string tag);
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty got_l=%b got_r=%b", tag, oL, oR);
    end else begin
      e = sb.pop_front();
      check({tag, "_l"}, oL, e[15:8]);
      check({tag, "_r"}, oR, e[7:0]);
      last_e = e;
      have_last = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] va [7] = '{8'd0, 8'd251, 8'd241, 8'd231, 8'd191, 8'd91, 8'd19};
    logic [2:0] vn [7] = '{3'd0, 3'd4, 3'd2, 3'd1, 3'd3, 3'd7, 3'd5};
    #1;
    check("rst_l", oL, 8'h00);
    check("rst_r", oR, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 8'($urandom);
      {s0, s1, s2} = 3'($urandom);
      @(posedge clk);
      #1;
      check("rst_hold_l", oL, 8'h00);
      check("rst_hold_r", oR, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(va[i], vn[i]);
      collect("vec");
    end
    for (int i = 0; i < 8; i++) begin
      drive(8'hA5, 3'(i));
      collect("sweep");
    end
    for (int i = 0; i < 40; i++) begin
      drive(8'($urandom), 3'($urandom));
      collect("b2b");
    end
    drive(8'hFF, 3'd0);
    collect("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_l", oL, 8'h00);
    check("async_rst_r", oR, 8'h00);
    sb.delete();
    have_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = 8'($urandom);
      {s0, s1, s2} = 3'($urandom);
      @(posedge clk);
      #1;
      check("mid_rst_l", oL, 8'h00);
      check("mid_rst_r", oR, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'd68, 3'd4);
    collect("post_rst");
    check("post_rst_lit_l", oL, 8'b01000000);
    check("post_rst_lit_r", oR, 8'b00000100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
